flit_assembler: RTL and testbench

Downstream consumer of the 4-stage flit delay line. Collects a fixed number of narrow flits into one wide word, least-significant flit first, and presents completed words through a 2-entry output queue with a valid/ready handshake. The upstream line has no backpressure, so the assembler accepts a flit on every valid cycle. Loss conditions are reported through sticky error flags instead of stalling.

---
 rtl/flit_pkg.sv | 21 ++
 rtl/flit_assembler_if.sv | 32 +++
 rtl/flit_assembler_word_queue.sv | 89 ++++++++
 rtl/flit_assembler.sv | 91 +++++++++
 tb/tb_flit_assembler.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/flit_pkg.sv
// Shared definitions for the flit path: default flit geometry and the
// helpers that derive the assembled word width and slot-counter width.
package flit_pkg;

  localparam int unsigned FLIT_W_DEFAULT         = 4;
  localparam int unsigned FLITS_PER_WORD_DEFAULT = 4;

  // Assembled word width for a given flit width and flit count.
  function automatic int unsigned word_width(int unsigned flit_w, int unsigned n_flits);
    return flit_w * n_flits;
  endfunction

  // Width of the slot index counter.
  function automatic int unsigned count_width(int unsigned n_flits);
    return $clog2(n_flits);
  endfunction

  localparam int unsigned WORD_W_DEFAULT =
    word_width(FLIT_W_DEFAULT, FLITS_PER_WORD_DEFAULT);

endpackage

// File: rtl/flit_assembler_if.sv
// Flit-in / word-out bundle of the flit assembler.
//   master: flit source and word consumer (drives flits, word_ready, clr_err)
//   slave : the assembler (drives word_data, word_valid, level, error flags)
interface flit_assembler_if
  import flit_pkg::*;
#(
  parameter int unsigned FLIT_W = FLIT_W_DEFAULT,
  parameter int unsigned WORD_W = WORD_W_DEFAULT
) ();

  logic [FLIT_W-1:0] flit_in;
  logic              flit_valid;
  logic              flit_sop;
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;
  logic [1:0]        level;
  logic              overflow;
  logic              frag_err;
  logic              clr_err;

  modport master (
    output flit_in, flit_valid, flit_sop, word_ready, clr_err,
    input  word_data, word_valid, level, overflow, frag_err
  );

  modport slave (
    input  flit_in, flit_valid, flit_sop, word_ready, clr_err,
    output word_data, word_valid, level, overflow, frag_err
  );

endinterface

// File: rtl/flit_assembler_word_queue.sv
// word_queue: fixed 2-entry FIFO with a registered head.
//   push_i/push_data_i : enqueue request (ignored when full unless popping)
//   pop_i              : dequeue request (ignored when empty)
//   head_o             : oldest entry; holds last popped value when empty
//   valid_o/level_o/full_o : registered occupancy status
module word_queue #(
  parameter int unsigned WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [WORD_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [WORD_W-1:0] head_o,
  output logic              valid_o,
  output logic [1:0]        level_o,
  output logic              full_o
);

  logic [WORD_W-1:0] head_q, head_d;
  logic [WORD_W-1:0] tail_q, tail_d;
  logic [1:0]        level_q, level_d;
  logic              valid_q, valid_d;
  logic              full_q, full_d;
  logic              pop_c;

  // Next-state: entries shift toward head on pop; a push when full is
  // only taken if the same edge pops.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level_q;
    pop_c   = pop_i & valid_q;
    case (level_q)
      2'd0: begin
        if (push_i) begin
          head_d  = push_data_i;
          level_d = 2'd1;
        end
      end
      2'd1: begin
        if (push_i && pop_c) begin
          head_d = push_data_i;
        end else if (push_i) begin
          tail_d  = push_data_i;
          level_d = 2'd2;
        end else if (pop_c) begin
          level_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop_c) begin
          head_d = tail_q;
          if (push_i) begin
            tail_d = push_data_i;
          end else begin
            level_d = 2'd1;
          end
        end
      end
      default: level_d = 2'd0;
    endcase
    valid_d = (level_d != 2'd0);
    full_d  = (level_d == 2'd2);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= 2'd0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
      valid_q <= valid_d;
      full_q  <= full_d;
    end
  end

  assign head_o  = head_q;
  assign valid_o = valid_q;
  assign level_o = level_q;
  assign full_o  = full_q;

endmodule

// File: rtl/flit_assembler.sv
// flit_assembler: packs FLITS_PER_WORD flits (LS flit first) into one word
// and queues completed words in a 2-entry output FIFO.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : slave side of flit_assembler_if (flits in, words out,
//              occupancy, sticky overflow/frag_err, clr_err)
module flit_assembler
  import flit_pkg::*;
#(
  parameter int unsigned FLIT_W         = FLIT_W_DEFAULT,
  parameter int unsigned FLITS_PER_WORD = FLITS_PER_WORD_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  flit_assembler_if.slave  bus
);

  localparam int unsigned WORD_W = word_width(FLIT_W, FLITS_PER_WORD);
  localparam int unsigned CNT_W  = count_width(FLITS_PER_WORD);
  localparam int unsigned ACC_W  = WORD_W - FLIT_W;
  localparam int unsigned LAST   = FLITS_PER_WORD - 1;

  logic [CNT_W-1:0]  count_q, count_d;
  // The last slot is never stored: it comes straight from flit_in.
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              overflow_q, overflow_d;
  logic              frag_q, frag_d;
  logic              frag_set_c;
  logic              push_c;
  logic [WORD_W-1:0] push_word_c;
  logic              pop_c;
  logic              full_c;
  logic              drop_c;

  // Slot write, completion detection and sticky flag updates.
  always_comb begin
    count_d     = count_q;
    acc_d       = acc_q;
    push_c      = 1'b0;
    frag_set_c  = 1'b0;
    push_word_c = {bus.flit_in, acc_q};
    if (bus.flit_valid) begin
      if (bus.flit_sop) begin
        acc_d[FLIT_W-1:0] = bus.flit_in;
        count_d           = CNT_W'(1);
        frag_set_c        = (count_q != '0);
      end else if (count_q == CNT_W'(LAST)) begin
        push_c  = 1'b1;
        count_d = '0;
      end else begin
        acc_d[32'(count_q)*FLIT_W +: FLIT_W] = bus.flit_in;
        count_d = count_q + CNT_W'(1);
      end
    end
    pop_c      = bus.word_valid & bus.word_ready;
    drop_c     = push_c & full_c & ~pop_c;
    // Set wins over a same-edge clear.
    overflow_d = drop_c | (overflow_q & ~bus.clr_err);
    frag_d     = frag_set_c | (frag_q & ~bus.clr_err);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= '0;
      acc_q      <= '0;
      overflow_q <= 1'b0;
      frag_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      acc_q      <= acc_d;
      overflow_q <= overflow_d;
      frag_q     <= frag_d;
    end
  end

  word_queue #(.WORD_W(WORD_W)) u_word_queue (
    .clk         (clk),
    .rst_n       (rst),
    .push_i      (push_c),
    .push_data_i (push_word_c),
    .pop_i       (pop_c),
    .head_o      (bus.word_data),
    .valid_o     (bus.word_valid),
    .level_o     (bus.level),
    .full_o      (full_c)
  );

  assign bus.overflow = overflow_q;
  assign bus.frag_err = frag_q;

endmodule

// File: tb/tb_flit_assembler.sv
// Scoreboard bench for flit_assembler: a list-based word builder predicts
// completed words, queue occupancy and sticky flags; a negedge monitor
// matches every handshaken word against the expected-word queue.
module tb_flit_assembler;
  import flit_pkg::*;

  localparam int unsigned FW = 4;
  localparam int unsigned N  = 4;
  localparam int unsigned WW = FW * N;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  flit_assembler_if #(.FLIT_W(FW), .WORD_W(WW)) bus ();

  flit_assembler #(.FLIT_W(FW), .FLITS_PER_WORD(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [WW-1:0] exp_q[$];     // words expected on the output, in order
  logic [FW-1:0] partial[$];   // flits of the word being assembled
  int            mocc = 0;     // expected queue occupancy
  bit            exp_ovf = 1'b0;
  bit            exp_frag = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: a handshake happening at the next edge pops the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.word_valid === 1'b1 && bus.word_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL word_unexpected: got %0h expected none at %0t", bus.word_data, $time);
      end else begin
        chk("word_data", 32'(bus.word_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // Reference model for one clock edge with the given inputs.
  task automatic model(input bit v, input bit s, input logic [FW-1:0] f,
                       input bit r, input bit c);
    bit            pop;
    bit            push;
    bit            fr;
    bit            ov;
    logic [WW-1:0] w;
    pop  = (mocc > 0) && r;
    push = 1'b0;
    fr   = 1'b0;
    ov   = 1'b0;
    w    = '0;
    if (v) begin
      if (s) begin
        if (partial.size() != 0) fr = 1'b1;
        partial.delete();
      end
      partial.push_back(f);
      if (partial.size() == N) begin
        foreach (partial[i]) w = w | (WW'(partial[i]) << (i * FW));
        push = 1'b1;
        partial.delete();
      end
    end
    if (push) begin
      if (mocc == 2 && !pop) ov = 1'b1;
      else begin
        exp_q.push_back(w);
        mocc++;
      end
    end
    if (pop) mocc--;
    exp_ovf  = ov | (exp_ovf & !c);
    exp_frag = fr | (exp_frag & !c);
  endtask

  // One cycle: check state left by the previous edge, then drive and predict.
  task automatic step(input bit v, input bit s, input logic [FW-1:0] f,
                      input bit r, input bit c);
    @(posedge clk);
    #1;
    chk("word_valid", 32'(bus.word_valid), 32'(mocc > 0));
    chk("level", 32'(bus.level), 32'(mocc));
    chk("overflow", 32'(bus.overflow), 32'(exp_ovf));
    chk("frag_err", 32'(bus.frag_err), 32'(exp_frag));
    bus.flit_valid = v;
    bus.flit_sop   = s;
    bus.flit_in    = f;
    bus.word_ready = r;
    bus.clr_err    = c;
    model(v, s, f, r, c);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, r, 1'b0);
  endtask

  // Four flits of w, LS first, sop on the first, ready held at r.
  task automatic send_word(input logic [WW-1:0] w, input bit r);
    logic [WW-1:0] t;
    t = w;
    for (int i = 0; i < N; i++) step(1'b1, i == 0, t[i*FW +: FW], r, 1'b0);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0;
    bus.flit_valid = 1'b0;
    bus.flit_sop   = 1'b0;
    bus.flit_in    = '0;
    bus.word_ready = 1'b0;
    bus.clr_err    = 1'b0;
    exp_q.delete();
    partial.delete();
    mocc     = 0;
    exp_ovf  = 1'b0;
    exp_frag = 1'b0;
    #1;
    chk("rst_word_valid", 32'(bus.word_valid), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_word_data", 32'(bus.word_data), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_frag_err", 32'(bus.frag_err), 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    do_reset();

    // Reset mid-word, then a clean word.
    step(1'b1, 1'b1, 4'h7, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'h8, 1'b1, 1'b0);
    do_reset();
    send_word(16'h4321, 1'b1);
    idle(3, 1'b1);
    chk("reset_midword_drained", 32'(exp_q.size()), 32'd0);

    // Back-to-back words with the consumer always ready.
    send_word(16'h4321, 1'b1);
    send_word(16'h8765, 1'b1);
    idle(3, 1'b1);

    // Backpressure: third word dropped, then drain A and B.
    do_reset();
    send_word(16'h4321, 1'b0);
    send_word(16'h8765, 1'b0);
    send_word(16'hCBA9, 1'b0);
    idle(2, 1'b0);
    chk("ovf_level_full", 32'(bus.level), 32'd2);
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    idle(4, 1'b1);

    // Push and pop on the same edge with the queue full.
    do_reset();
    send_word(16'h1111, 1'b0);
    send_word(16'h2222, 1'b0);
    step(1'b1, 1'b1, 4'h3, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'h3, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'h3, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'h3, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("pushpop_level", 32'(bus.level), 32'd2);
    chk("pushpop_overflow", 32'(bus.overflow), 32'd0);
    idle(4, 1'b1);

    // Fragment, then clr_err racing a new fragment, then clr_err alone.
    do_reset();
    step(1'b1, 1'b1, 4'h5, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'h6, 1'b1, 1'b0);
    send_word(16'h4321, 1'b1);
    step(1'b1, 1'b1, 4'h5, 1'b1, 1'b0);
    step(1'b1, 1'b1, 4'h7, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("frag_clr_race", 32'(bus.frag_err), 32'd1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("frag_clr_alone", 32'(bus.frag_err), 32'd0);

    // Gaps between flits.
    do_reset();
    step(1'b1, 1'b1, 4'hA, 1'b1, 1'b0);
    idle(3, 1'b1);
    step(1'b1, 1'b0, 4'hB, 1'b1, 1'b0);
    idle(3, 1'b1);
    step(1'b1, 1'b0, 4'hC, 1'b1, 1'b0);
    idle(3, 1'b1);
    step(1'b1, 1'b0, 4'hD, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Randomised traffic.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bit v;
      v = ($urandom_range(0, 3) != 0);
      step(v, v && ($urandom_range(0, 5) == 0), FW'($urandom),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
    end
    idle(4, 1'b1);
    @(negedge clk);
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
